prop_monitor: RTL and testbench
===============================

# prop_monitor

Downstream checking stage for the diagonal X/Y counter. It samples the counter's one-bit `prop` output every enabled cycle and counts violations (cycles with `prop` low). It declares a sticky failure once `prop` has been low for `TOL` consecutive sampled cycles, and records the sample index of that failure. It gives the formal and simulation flows one registered pass/fail verdict instead of a raw per-cycle invariant.

## Interface
- `CW`, default 8: width of the sample counter and of `fail_cycle`.
- `VW`, default 4: width of the violation counter.
- `TOL`, default 2: consecutive low samples that trigger a failure. Legal range is 1..15.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `en`, input, 1: sample enable. `prop` is evaluated only in cycles where `en` is 1.
- `prop`, input, 1: invariant from the diagonal counter. 1 means it holds.
- `state`, output, 2: current FSM state (encoding below).
- `fail`, output, 1: sticky failure flag.
- `fail_cycle`, output, CW: index of the sample that caused the failure.
- `cycle_cnt`, output, CW: number of samples taken. Saturates.
- `viol_count`, output, VW: number of low samples. Saturates.
- `low_run`, output, 4: current run of consecutive low samples.

## Operation
- **Sampled cycle:** `en` is 1, `reset` is 0 and `state` is not FAILED.
- **States:** IDLE=0, WATCH=1, SUSPECT=2, FAILED=3.
- **Reset:** all outputs go to 0 and `state` goes to IDLE. Reset dominates `en`, `prop` and every state, including FAILED.
- **Every sampled cycle:** `cycle_cnt` increments, saturating at 2^CW−1.
- **Sampled cycle with `prop`=1:** `low_run` goes to 0 and the next state is WATCH, from IDLE, WATCH or SUSPECT.
- **Sampled cycle with `prop`=0:**
  - `viol_count` increments, saturating at 2^VW−1.
  - The new run length `r` is `low_run`+1.
  - If `r` ≥ `TOL`: next state is FAILED, `fail` is set to 1, `fail_cycle` takes the pre-increment `cycle_cnt` (0-based index of this sample), and `low_run` takes `r`.
  - Otherwise: next state is SUSPECT and `low_run` takes `r`.
- **`en`=0 in IDLE, WATCH or SUSPECT:** all registers hold. A run of low samples is not broken by an enable gap.
- **FAILED:** absorbing until reset. All counters, `fail_cycle` and `low_run` are frozen regardless of `en` and `prop`.
- **`TOL`=1:** the first low sample goes directly to FAILED. SUSPECT is unreachable.
- **`cycle_cnt` saturated:** a failure at that point records `fail_cycle` = 2^CW−1.
- **Out-of-range `TOL`:** compile-time error via an elaboration check.

## Timing
- All outputs are registered. There are no combinational paths from input to output.
- A sample taken at rising edge k is reflected in every output immediately after edge k (latency 1 edge).
- `fail` rises after the same edge that samples the `TOL`-th consecutive low `prop`.
- When reset is applied at edge k, all outputs are 0 after edge k. The first sample can be taken at edge k+1 if `reset` is 0 then.
- There is no handshake. The upstream counter is free-running, and `en` qualifies its output cycle by cycle.

## Structure
- Shared package `diag_pkg` holds:
  - the state enum (IDLE, WATCH, SUSPECT, FAILED);
  - the default `CW`, `VW` and `TOL` constants;
  - a `W` constant shared with the diagonal counter.
- Sub-module `sat_counter` (parameter `N`; ports `clk`, `reset`, `inc`, `hold`, `q`) is instantiated twice, for `cycle_cnt` and `viol_count`.
- The FSM and the capture of `low_run` and `fail_cycle` live in `prop_monitor`.

## Test plan
All scenarios use default parameters (`CW`=8, `VW`=4, `TOL`=2) unless stated.

1. **All-pass run:** reset, then `en`=1 with `prop`=1 for 10 cycles → `state`=WATCH, `cycle_cnt`=10, `viol_count`=0, `low_run`=0, `fail`=0.
2. **Isolated violations:** `prop` sequence 1,0,1,0,1 with `en`=1 → `viol_count`=2, `fail`=0, `state`=WATCH. `state` is SUSPECT after the 2nd and 4th samples.
3. **Failure and freeze:** `prop` sequence 1,1,1,0,0 → `fail`=1 after the 5th edge, `fail_cycle`=4, `viol_count`=2, `low_run`=2, `state`=FAILED. Twenty more cycles with `prop`=1 leave all outputs unchanged.
4. **Enable gap:** `prop`=0 sampled, then `en`=0 for 3 cycles with `prop` toggling, then `en`=1 with `prop`=0 → `fail`=1, `fail_cycle`=1, `cycle_cnt`=2.
5. **Saturation:**
   - 40 samples alternating 1,0 → `viol_count` holds at 15 and `fail`=0.
   - 300 samples with `prop`=1 → `cycle_cnt`=255.
   - A subsequent 0,0 → `fail_cycle`=255.
6. **Reset dominance:** in FAILED, assert `reset` with `en`=1 and `prop`=0 → after that edge all outputs are 0 and `state`=IDLE. With `TOL`=1, a single low sample → FAILED after one edge.

Source files
------------

// File: rtl/diag_pkg.sv
// ==========================================================================
// diag_pkg : shared types and defaults for the diagonal counter and its monitor
// Revision : 1.0
// ==========================================================================
`default_nettype none

package diag_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WATCH   = 2'd1,
    SUSPECT = 2'd2,
    FAILED  = 2'd3
  } mon_state_e;

  localparam int DEF_CW  = 8;
  localparam int DEF_VW  = 4;
  localparam int DEF_TOL = 2;
  localparam int W       = 4;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ==========================================================================
// sat_counter : N-bit up counter that sticks at all-ones and can be frozen
// Revision    : 1.0
// ==========================================================================
`default_nettype none

module sat_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         hold,
  output logic [N-1:0] q
);

  localparam logic [N-1:0] C_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc && !hold && (q_q != {N{1'b1}})) begin
      q_d = q_q + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/prop_monitor.sv
// ==========================================================================
// prop_monitor : samples the diagonal counter's invariant and latches a sticky
//                pass/fail verdict after TOL consecutive low samples
// Revision     : 1.0
// ==========================================================================
`default_nettype none

module prop_monitor
  import diag_pkg::*;
#(
  parameter int CW  = DEF_CW,
  parameter int VW  = DEF_VW,
  parameter int TOL = DEF_TOL
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          prop,
  output logic [1:0]    state,
  output logic          fail,
  output logic [CW-1:0] fail_cycle,
  output logic [CW-1:0] cycle_cnt,
  output logic [VW-1:0] viol_count,
  output logic [3:0]    low_run
);

  generate
    if (TOL < 1 || TOL > 15) begin : g_tol_check
      $error("prop_monitor: TOL must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] C_TOL = 4'(TOL);

  mon_state_e    state_q, state_d;
  logic          fail_q, fail_d;
  logic [CW-1:0] fail_cycle_q, fail_cycle_d;
  logic [3:0]    low_run_q, low_run_d;
  logic [3:0]    w_run_nxt;
  logic          w_sampled;
  logic          w_frozen;
  logic [CW-1:0] w_cycle_cnt;
  logic [VW-1:0] w_viol_count;

  assign w_frozen  = (state_q == FAILED);
  assign w_sampled = en && !w_frozen;
  assign w_run_nxt = low_run_q + 4'd1;

  sat_counter #(.N(CW)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (en),
    .hold  (w_frozen),
    .q     (w_cycle_cnt)
  );

  sat_counter #(.N(VW)) u_viol_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (en && !prop),
    .hold  (w_frozen),
    .q     (w_viol_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      fail_q       <= 1'b0;
      fail_cycle_q <= '0;
      low_run_q    <= '0;
    end else begin
      state_q      <= state_d;
      fail_q       <= fail_d;
      fail_cycle_q <= fail_cycle_d;
      low_run_q    <= low_run_d;
    end
  end

  // The low run survives enable gaps: it only clears on a sampled high.
  always_comb begin
    state_d      = state_q;
    fail_d       = fail_q;
    fail_cycle_d = fail_cycle_q;
    low_run_d    = low_run_q;
    if (w_sampled) begin
      if (prop) begin
        state_d   = WATCH;
        low_run_d = 4'd0;
      end else begin
        low_run_d = w_run_nxt;
        if (w_run_nxt >= C_TOL) begin
          state_d      = FAILED;
          fail_d       = 1'b1;
          fail_cycle_d = w_cycle_cnt;
        end else begin
          state_d = SUSPECT;
        end
      end
    end
  end

  always_comb begin
    state      = state_q;
    fail       = fail_q;
    fail_cycle = fail_cycle_q;
    cycle_cnt  = w_cycle_cnt;
    viol_count = w_viol_count;
    low_run    = low_run_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_prop_monitor.sv
// ==========================================================================
// tb_prop_monitor : directed vectors against hand-computed monitor outputs
// Revision        : 1.0
// ==========================================================================
`default_nettype none

module tb_prop_monitor;

  logic       clk;
  logic       reset;
  logic       en;
  logic       prop;

  logic [1:0] state,  state1;
  logic       fail,   fail1;
  logic [7:0] fcyc,   fcyc1;
  logic [7:0] ccnt,   ccnt1;
  logic [3:0] vcnt,   vcnt1;
  logic [3:0] lrun,   lrun1;

  int n_checks;
  int n_fail;

  prop_monitor #(.CW(8), .VW(4), .TOL(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .prop       (prop),
    .state      (state),
    .fail       (fail),
    .fail_cycle (fcyc),
    .cycle_cnt  (ccnt),
    .viol_count (vcnt),
    .low_run    (lrun)
  );

  prop_monitor #(.CW(8), .VW(4), .TOL(1)) dut_tol1 (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .prop       (prop),
    .state      (state1),
    .fail       (fail1),
    .fail_cycle (fcyc1),
    .cycle_cnt  (ccnt1),
    .viol_count (vcnt1),
    .low_run    (lrun1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic p);
    @(negedge clk);
    reset = 1'b0;
    en    = e;
    prop  = p;
    @(posedge clk);
    #1;
  endtask

  // Reset with en=1/prop=0 so reset dominance is exercised every time.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b1;
    prop  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_all(input string tag, input int st, input int f, input int fc,
                           input int cc, input int vc, input int lr);
    check({tag, "_state"},      32'(state), st);
    check({tag, "_fail"},       32'(fail),  f);
    check({tag, "_fail_cycle"}, 32'(fcyc),  fc);
    check({tag, "_cycle_cnt"},  32'(ccnt),  cc);
    check({tag, "_viol_count"}, 32'(vcnt),  vc);
    check({tag, "_low_run"},    32'(lrun),  lr);
  endtask

  initial begin
    logic [4:0] seq;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    en    = 1'b0;
    prop  = 1'b0;

    do_reset();
    check_all("reset", 0, 0, 0, 0, 0, 0);

    // 1: all-pass run
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    check_all("allpass", 1, 0, 0, 10, 0, 0);

    // 2: isolated violations 1,0,1,0,1
    do_reset();
    seq = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[4-i]);
      if (i == 1 || i == 3) check($sformatf("iso_suspect%0d", i), 32'(state), 2);
    end
    check_all("iso", 1, 0, 0, 5, 2, 0);

    // 3: failure then freeze
    do_reset();
    seq = 5'b11100;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[4-i]);
      if (i == 3) check("fail_pre_lowrun", 32'(lrun), 1);
    end
    check_all("fail", 3, 1, 4, 5, 2, 2);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    check_all("freeze", 3, 1, 4, 5, 2, 2);

    // 4: enable gap does not break the low run
    do_reset();
    step(1'b1, 1'b0);
    check_all("gap_first", 2, 0, 0, 1, 1, 1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check_all("gap_hold", 2, 0, 0, 1, 1, 1);
    step(1'b1, 1'b0);
    check_all("gap_fail", 3, 1, 1, 2, 2, 2);

    // 5: saturation
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, (i % 2) == 0);
    check_all("sat_viol", 2, 0, 0, 40, 15, 1);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1);
    check_all("sat_cnt", 1, 0, 0, 255, 15, 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check_all("sat_fail", 3, 1, 255, 255, 15, 2);

    // 6: reset dominates FAILED, then TOL=1 fails on first low
    do_reset();
    check_all("rst_dom", 0, 0, 0, 0, 0, 0);
    check("tol1_rst_state", 32'(state1), 0);
    step(1'b1, 1'b0);
    check("tol1_state",      32'(state1), 3);
    check("tol1_fail",       32'(fail1),  1);
    check("tol1_fail_cycle", 32'(fcyc1),  0);
    check("tol1_low_run",    32'(lrun1),  1);
    check("tol1_viol",       32'(vcnt1),  1);
    check("tol2_suspect",    32'(state),  2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
